// File: rtl/sprite_pkg.sv
// Shared definitions for the per-scanline sprite evaluator: FSM encoding,
// OAM byte layout, attribute mask and sprite heights.
package sprite_pkg;
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE_Y = 3'd1,
      ST_CHECK   = 3'd2,
      ST_COPY1   = 3'd3,
      ST_COPY2   = 3'd4,
      ST_COPY3   = 3'd5,
      ST_DONE    = 3'd6
   } eval_state_e;

   localparam logic [1:0] OAM_Y    = 2'd0;
   localparam logic [1:0] OAM_TILE = 2'd1;
   localparam logic [1:0] OAM_ATTR = 2'd2;
   localparam logic [1:0] OAM_X    = 2'd3;

   localparam logic [7:0] ATTR_MASK = 8'hE3;

   localparam logic [9:0] HEIGHT_SHORT = 10'd8;
   localparam logic [9:0] HEIGHT_TALL  = 10'd16;
endpackage

// File: rtl/sprite_secondary_buffer.sv
// Secondary OAM: MAX_PER_LINE slots of 4 bytes, one synchronous write port and
// one combinational read port that returns 8'hFF for slots at or above count.
module sprite_secondary_buffer
   import sprite_pkg::*;
#(
   parameter int MAX_PER_LINE = 8,
   parameter int IDX_W        = 3,
   parameter int CNT_W        = 4
) (
   input  logic             clock,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_slot_i,
   input  logic [1:0]       wr_byte_i,
   input  logic [7:0]       wr_data_i,
   input  logic [IDX_W-1:0] rd_slot_i,
   input  logic [1:0]       rd_byte_i,
   input  logic [CNT_W-1:0] count_i,
   output logic [7:0]       rd_data_o
);
   // Storage is never bulk-cleared; the count guard hides stale slots.
   logic [7:0] mem_q [MAX_PER_LINE][4];
   logic       slot_valid;

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_slot_i][wr_byte_i] <= wr_data_i;
      end
   end

   assign slot_valid = CNT_W'(rd_slot_i) < count_i;
   assign rd_data_o  = slot_valid ? mem_q[rd_slot_i][rd_byte_i] : 8'hFF;
endmodule

// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite evaluation: scans primary OAM on lineStart, copies up to
// MAX_PER_LINE in-range sprites into the secondary buffer, tracks zero/overflow.
module sprite_line_evaluator
   import sprite_pkg::*;
#(
   parameter int  NUM_SPRITES  = 64,
   parameter int  MAX_PER_LINE = 8,
   parameter int  HIDDEN_Y     = 240,
   localparam int ADDR_W       = $clog2(NUM_SPRITES * 4),
   localparam int N_W          = $clog2(NUM_SPRITES),
   localparam int IDX_W        = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1,
   localparam int CNT_W        = $clog2(MAX_PER_LINE) + 1
) (
   input  logic              clock,
   input  logic              reset_N,
   input  logic              clock_EN,
   input  logic              lineStart,
   input  logic [8:0]        yPosition,
   input  logic              tallSprites,
   input  logic              resetFlags,
   output logic [ADDR_W-1:0] oamAddress_OUT,
   input  logic [7:0]        oamData_IN,
   input  logic [IDX_W-1:0]  fetchIndex,
   input  logic [1:0]        fetchByte,
   output logic [7:0]        fetchData_OUT,
   output logic [CNT_W-1:0]  spriteCount_OUT,
   output logic              spriteZeroOnLine_OUT,
   output logic              spriteOverflow,
   output logic              evalDone_OUT
);
   eval_state_e      state_q, state_d;
   logic [N_W-1:0]   n_q, n_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic             wr_en;
   logic [1:0]       wr_byte;
   logic [7:0]       wr_data;
   logic [1:0]       addr_lo;
   logic [9:0]       y_ext, line_ext, line_delta, height;
   logic             hit, room, last;

   // Range test in 10 bits so yPosition - Y never wraps into a false hit.
   assign y_ext      = {2'b00, oamData_IN};
   assign line_ext   = {1'b0, yPosition};
   assign line_delta = line_ext - y_ext;
   assign height     = tallSprites ? HEIGHT_TALL : HEIGHT_SHORT;
   assign hit        = (y_ext < 10'(HIDDEN_Y)) && (line_ext >= y_ext) && (line_delta < height);
   assign room       = count_q < CNT_W'(MAX_PER_LINE);
   assign last       = n_q == N_W'(NUM_SPRITES - 1);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      count_d = count_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      wr_byte = OAM_Y;
      wr_data = oamData_IN;
      if (lineStart) begin
         state_d = ST_ISSUE_Y;
         n_d     = '0;
         count_d = '0;
         zero_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ISSUE_Y: state_d = ST_CHECK;
            ST_CHECK: begin
               if (hit && room) begin
                  wr_en   = 1'b1;
                  state_d = ST_COPY1;
                  if (n_q == '0) zero_d = 1'b1;
               end else if (hit) begin
                  ovf_d   = 1'b1;
                  state_d = ST_DONE;
               end else if (last) begin
                  state_d = ST_DONE;
               end else begin
                  n_d     = n_q + 1'b1;
                  state_d = ST_ISSUE_Y;
               end
            end
            ST_COPY1: begin
               wr_en   = 1'b1;
               wr_byte = OAM_TILE;
               state_d = ST_COPY2;
            end
            ST_COPY2: begin
               wr_en   = 1'b1;
               wr_byte = OAM_ATTR;
               wr_data = oamData_IN & ATTR_MASK;
               state_d = ST_COPY3;
            end
            ST_COPY3: begin
               wr_en   = 1'b1;
               wr_byte = OAM_X;
               count_d = count_q + 1'b1;
               if (last) begin
                  state_d = ST_DONE;
               end else begin
                  n_d     = n_q + 1'b1;
                  state_d = ST_ISSUE_Y;
               end
            end
            default: ;
         endcase
      end
      if (resetFlags) ovf_d = 1'b0;
      if (!clock_EN) wr_en = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         count_q <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (clock_EN) begin
         state_q <= state_d;
         n_q     <= n_d;
         count_q <= count_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end

   // Each state presents the address whose data the following state consumes.
   always_comb begin
      case (state_q)
         ST_CHECK: addr_lo = OAM_TILE;
         ST_COPY1: addr_lo = OAM_ATTR;
         ST_COPY2: addr_lo = OAM_X;
         default:  addr_lo = OAM_Y;
      endcase
   end

   assign oamAddress_OUT       = {n_q, addr_lo};
   assign spriteCount_OUT      = count_q;
   assign spriteZeroOnLine_OUT = zero_q;
   assign spriteOverflow       = ovf_q;
   assign evalDone_OUT         = state_q == ST_DONE;

   sprite_secondary_buffer #(
      .MAX_PER_LINE(MAX_PER_LINE),
      .IDX_W       (IDX_W),
      .CNT_W       (CNT_W)
   ) u_buffer (
      .clock    (clock),
      .wr_en_i  (wr_en),
      .wr_slot_i(count_q[IDX_W-1:0]),
      .wr_byte_i(wr_byte),
      .wr_data_i(wr_data),
      .rd_slot_i(fetchIndex),
      .rd_byte_i(fetchByte),
      .count_i  (count_q),
      .rd_data_o(fetchData_OUT)
   );
endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Directed bench for sprite_line_evaluator: default-size and MAX_PER_LINE=16
// instances share stimulus; each has its own one-cycle-latency OAM read model.
module tb_sprite_line_evaluator;
   logic       clock = 1'b0;
   logic       reset_N = 1'b0;
   logic       clock_EN = 1'b0;
   logic       lineStart = 1'b0;
   logic [8:0] yPosition = '0;
   logic       tallSprites = 1'b0;
   logic       resetFlags = 1'b0;
   logic [1:0] fetchByte = '0;
   logic [2:0] fetchIndex8 = '0;
   logic [3:0] fetchIndex16 = '0;

   logic [7:0] oam_mem [256];
   logic [7:0] oam_data8 = '0, oam_data16 = '0;
   logic [7:0] oam_addr8, oam_addr16;
   logic [7:0] fetch8, fetch16;
   logic [3:0] count8;
   logic [4:0] count16;
   logic       zero8, zero16, ovf8, ovf16, done8, done16;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_attr [8] = '{8'hE1, 8'hE2, 8'hE3, 8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE0};

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (clock_EN) begin
         oam_data8  <= oam_mem[oam_addr8];
         oam_data16 <= oam_mem[oam_addr16];
      end
   end

   sprite_line_evaluator #(.NUM_SPRITES(64), .MAX_PER_LINE(8), .HIDDEN_Y(240)) dut8 (
      .clock(clock), .reset_N(reset_N), .clock_EN(clock_EN), .lineStart(lineStart),
      .yPosition(yPosition), .tallSprites(tallSprites), .resetFlags(resetFlags),
      .oamAddress_OUT(oam_addr8), .oamData_IN(oam_data8),
      .fetchIndex(fetchIndex8), .fetchByte(fetchByte), .fetchData_OUT(fetch8),
      .spriteCount_OUT(count8), .spriteZeroOnLine_OUT(zero8),
      .spriteOverflow(ovf8), .evalDone_OUT(done8)
   );

   sprite_line_evaluator #(.NUM_SPRITES(64), .MAX_PER_LINE(16), .HIDDEN_Y(240)) dut16 (
      .clock(clock), .reset_N(reset_N), .clock_EN(clock_EN), .lineStart(lineStart),
      .yPosition(yPosition), .tallSprites(tallSprites), .resetFlags(resetFlags),
      .oamAddress_OUT(oam_addr16), .oamData_IN(oam_data16),
      .fetchIndex(fetchIndex16), .fetchByte(fetchByte), .fetchData_OUT(fetch16),
      .spriteCount_OUT(count16), .spriteZeroOnLine_OUT(zero16),
      .spriteOverflow(ovf16), .evalDone_OUT(done16)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_line(input int y, input logic tall);
      lineStart   = 1'b1;
      yPosition   = 9'(y);
      tallSprites = tall;
      step();
      lineStart   = 1'b0;
   endtask

   task automatic wait_done8(input int exp_cycles, input string tag);
      int c = 0;
      while (done8 !== 1'b1 && c < 400) begin
         step();
         c++;
      end
      $display("scan %s: %0d cycles, count %0d, overflow %0d", tag, c, count8, ovf8);
      chk(tag, c, exp_cycles);
   endtask

   task automatic wait_done16(input int exp_cycles, input string tag);
      int c = 0;
      while (done16 !== 1'b1 && c < 400) begin
         step();
         c++;
      end
      $display("scan %s: %0d cycles, count %0d, overflow %0d", tag, c, count16, ovf16);
      chk(tag, c, exp_cycles);
   endtask

   task automatic chk_fetch8(input string tag, input int idx, input int b, input logic [7:0] exp);
      fetchIndex8 = 3'(idx);
      fetchByte   = 2'(b);
      step();
      chk(tag, fetch8, exp);
   endtask

   task automatic fill_hidden();
      for (int i = 0; i < 256; i++) oam_mem[i] = 8'hFF;
   endtask

   task automatic set_sprite(input int n, input logic [7:0] y, input logic [7:0] t,
                             input logic [7:0] a, input logic [7:0] x);
      oam_mem[4*n]   = y;
      oam_mem[4*n+1] = t;
      oam_mem[4*n+2] = a;
      oam_mem[4*n+3] = x;
   endtask

   initial begin
      fill_hidden();
      step();
      step();
      chk("rst_addr", oam_addr8, 0);
      chk("rst_count", count8, 0);
      chk("rst_zero", zero8, 0);
      chk("rst_ovf", ovf8, 0);
      chk("rst_done", done8, 0);
      chk("rst_fetch", fetch8, 8'hFF);
      reset_N  = 1'b1;
      clock_EN = 1'b1;
      step();

      // All sprites hidden
      start_line(10, 1'b0);
      wait_done8(128, "hidden_cycles");
      chk("hidden_count", count8, 0);
      chk("hidden_ovf", ovf8, 0);
      for (int k = 0; k < 8; k++) chk_fetch8($sformatf("hidden_fetch%0d", k), k, k % 4, 8'hFF);

      // Single hit on sprite 0
      set_sprite(0, 8'd5, 8'h12, 8'hFF, 8'h40);
      start_line(12, 1'b0);
      wait_done8(131, "one_cycles");
      chk("one_count", count8, 1);
      chk("one_zero", zero8, 1);
      chk_fetch8("one_y", 0, 0, 8'h05);
      chk_fetch8("one_tile", 0, 1, 8'h12);
      chk_fetch8("one_attr", 0, 2, 8'hE3);
      chk_fetch8("one_x", 0, 3, 8'h40);
      chk_fetch8("one_slot1", 1, 1, 8'hFF);

      // Height and hidden-Y boundaries
      start_line(13, 1'b0);
      wait_done8(128, "short_miss_cycles");
      chk("short_miss_count", count8, 0);
      chk("short_miss_zero", zero8, 0);
      start_line(13, 1'b1);
      wait_done8(131, "tall_hit_cycles");
      chk("tall_hit_count", count8, 1);
      oam_mem[0] = 8'd240;
      start_line(240, 1'b1);
      wait_done8(128, "hiddeny_cycles");
      chk("hiddeny_count", count8, 0);
      oam_mem[0] = 8'd239;
      start_line(240, 1'b0);
      wait_done8(131, "y239_cycles");
      chk("y239_count", count8, 1);

      // Nine sprites on one line
      fill_hidden();
      for (int i = 1; i <= 9; i++)
         set_sprite(i, 8'd20, 8'(8'h10 + i), 8'(8'hF0 + i), 8'(8'h80 + i));
      start_line(20, 1'b0);
      wait_done8(44, "ovf_cycles");
      chk("ovf_count", count8, 8);
      chk("ovf_flag", ovf8, 1);
      chk("ovf_zero", zero8, 0);
      wait_done16(111, "ovf16_cycles");
      chk("ovf16_count", count16, 9);
      chk("ovf16_flag", ovf16, 0);
      for (int k = 0; k < 8; k++) begin
         chk_fetch8($sformatf("ovf_tile%0d", k), k, 1, 8'(8'h11 + k));
         chk_fetch8($sformatf("ovf_attr%0d", k), k, 2, exp_attr[k]);
      end
      chk_fetch8("ovf_y0", 0, 0, 8'h14);
      chk_fetch8("ovf_x7", 7, 3, 8'h88);
      fetchIndex16 = 4'd8;
      fetchByte    = 2'd1;
      step();
      chk("ovf16_tile8", fetch16, 8'h19);

      // Overflow is sticky across lineStart; async reset mid-scan
      start_line(20, 1'b0);
      chk("ovf_sticky", ovf8, 1);
      for (int k = 0; k < 10; k++) step();
      chk("pre_rst_addr", oam_addr8, 8'd11);
      chk("pre_rst_count", count8, 1);
      fetchIndex8 = 3'd0;
      fetchByte   = 2'd0;
      #2 reset_N = 1'b0;
      #1;
      chk("arst_addr", oam_addr8, 0);
      chk("arst_count", count8, 0);
      chk("arst_ovf", ovf8, 0);
      chk("arst_done", done8, 0);
      chk("arst_fetch", fetch8, 8'hFF);
      step();
      reset_N = 1'b1;
      step();
      chk("post_rst_addr", oam_addr8, 0);
      chk("post_rst_done", done8, 0);

      // resetFlags clears overflow
      start_line(20, 1'b0);
      wait_done8(44, "flags_cycles");
      chk("flags_ovf_set", ovf8, 1);
      resetFlags = 1'b1;
      step();
      resetFlags = 1'b0;
      chk("flags_ovf_clr", ovf8, 0);

      // lineStart aborts a scan in COPY2
      fill_hidden();
      set_sprite(0, 8'd5, 8'h12, 8'hFF, 8'h40);
      start_line(12, 1'b0);
      step();
      step();
      step();
      fetchIndex8 = 3'd0;
      fetchByte   = 2'd0;
      start_line(100, 1'b0);
      chk("abort_count", count8, 0);
      chk("abort_fetch", fetch8, 8'hFF);
      wait_done8(128, "abort_cycles");
      chk("abort_final_count", count8, 0);
      chk("abort_zero", zero8, 0);

      // clock_EN low for five cycles mid-scan
      start_line(12, 1'b0);
      for (int k = 0; k < 10; k++) step();
      clock_EN = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("stall_done", done8, 0);
      clock_EN = 1'b1;
      wait_done8(121, "stall_cycles");
      chk("stall_count", count8, 1);
      chk("stall_zero", zero8, 1);
      chk_fetch8("stall_tile", 0, 1, 8'h12);
      chk_fetch8("stall_attr", 0, 2, 8'hE3);
      chk_fetch8("stall_x", 0, 3, 8'h40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
